// File: rtl/ycbcr_pkg.sv
// Shared YCbCr colour-space constants and helpers for the forward and inverse converters.
package ycbcr_pkg;

    localparam int K_R_CR     = 359;
    localparam int K_G_CB     = 88;
    localparam int K_G_CR     = 183;
    localparam int K_B_CB     = 454;
    localparam int SUM_W      = 18;
    localparam int CHROMA_OFS = 128;
    localparam int PIPE_LAT   = 4;

    typedef logic signed [SUM_W-1:0] sum_t;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } sync_t;

    // Floor-divide a x256 fixed-point sum by 256 and clamp to an unsigned 8-bit level.
    function automatic logic [7:0] clamp_u8(input sum_t s);
        sum_t shifted;
        shifted = s >>> 8;
        if (shifted < 0) begin
            return 8'd0;
        end else if (shifted > sum_t'(255)) begin
            return 8'd255;
        end else begin
            return shifted[7:0];
        end
    endfunction

    // Add with saturation at 255, used by the rounding 888->565 reduction.
    function automatic logic [7:0] sat_add_u8(input logic [7:0] v, input logic [7:0] inc);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/ycbcr2rgb565_if.sv
// Pixel bus for the YCbCr->RGB565 converter: YCbCr stream in, RGB565 stream out.
interface ycbcr2rgb565_if;

    logic       pre_frame_vsync;
    logic       pre_frame_hsync;
    logic       pre_frame_de;
    logic [7:0] img_y;
    logic [7:0] img_cb;
    logic [7:0] img_cr;

    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_de;
    logic [4:0] img_red;
    logic [5:0] img_green;
    logic [4:0] img_blue;

    // Source side: drives YCbCr pixels, consumes RGB565 pixels.
    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de,
        output img_y, img_cb, img_cr,
        input  post_frame_vsync, post_frame_hsync, post_frame_de,
        input  img_red, img_green, img_blue
    );

    // Converter side.
    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de,
        input  img_y, img_cb, img_cr,
        output post_frame_vsync, post_frame_hsync, post_frame_de,
        output img_red, img_green, img_blue
    );

endinterface

// File: rtl/video_sync_dly.sv
// DEPTH-stage delay line for {vsync,hsync,de}, keeping timing aligned with a pixel pipeline.
module video_sync_dly #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sync_in,
    output logic [2:0] sync_out
);

    logic [DEPTH-1:0][2:0] sh_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg <= '0;
        end else begin
            sh_reg[0] <= sync_in;
            for (int i = 1; i < DEPTH; i++) begin
                sh_reg[i] <= sh_reg[i-1];
            end
        end
    end

    assign sync_out = sh_reg[DEPTH-1];

endmodule

// File: rtl/ycbcr2rgb565.sv
// 4-stage YCbCr 4:4:4 -> RGB565 converter with saturation and blanking.
// Define YCBCR2RGB_ROUND_EN to round half-up in the 888->565 reduction (truncates otherwise).
module ycbcr2rgb565
    import ycbcr_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    ycbcr2rgb565_if.slave       bus
);

    localparam sum_t C_R_CR = sum_t'(K_R_CR);
    localparam sum_t C_G_CB = sum_t'(K_G_CB);
    localparam sum_t C_G_CR = sum_t'(K_G_CR);
    localparam sum_t C_B_CB = sum_t'(K_B_CB);

    // Stage 1: centred chroma and coefficient products
    logic signed [8:0] cb_s;
    logic signed [8:0] cr_s;
    sum_t              cb_x;
    sum_t              cr_x;

    assign cb_s = $signed({1'b0, bus.img_cb}) - $signed(9'(CHROMA_OFS));
    assign cr_s = $signed({1'b0, bus.img_cr}) - $signed(9'(CHROMA_OFS));
    assign cb_x = sum_t'(cb_s);
    assign cr_x = sum_t'(cr_s);

    sum_t p_y_reg;
    sum_t p_r_cr_reg;
    sum_t p_g_cb_reg;
    sum_t p_g_cr_reg;
    sum_t p_b_cb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_y_reg    <= '0;
            p_r_cr_reg <= '0;
            p_g_cb_reg <= '0;
            p_g_cr_reg <= '0;
            p_b_cb_reg <= '0;
        end else begin
            p_y_reg    <= sum_t'({2'b00, bus.img_y, 8'h00});
            p_r_cr_reg <= cr_x * C_R_CR;
            p_g_cb_reg <= cb_x * C_G_CB;
            p_g_cr_reg <= cr_x * C_G_CR;
            p_b_cb_reg <= cb_x * C_B_CB;
        end
    end

    // Stage 2: channel sums; the bounded input range keeps them inside 18 bits
    sum_t s_r_reg;
    sum_t s_g_reg;
    sum_t s_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r_reg <= '0;
            s_g_reg <= '0;
            s_b_reg <= '0;
        end else begin
            s_r_reg <= p_y_reg + p_r_cr_reg;
            s_g_reg <= p_y_reg - p_g_cb_reg - p_g_cr_reg;
            s_b_reg <= p_y_reg + p_b_cb_reg;
        end
    end

    // Stage 3: floor shift and clamp to 8 bits
    logic [7:0] c_r_reg;
    logic [7:0] c_g_reg;
    logic [7:0] c_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r_reg <= '0;
            c_g_reg <= '0;
            c_b_reg <= '0;
        end else begin
            c_r_reg <= clamp_u8(s_r_reg);
            c_g_reg <= clamp_u8(s_g_reg);
            c_b_reg <= clamp_u8(s_b_reg);
        end
    end

    // Stage 4: 888 -> 565 reduction
    logic [4:0] r5_next;
    logic [5:0] g6_next;
    logic [4:0] b5_next;

`ifdef YCBCR2RGB_ROUND_EN
    logic [7:0] r_rnd;
    logic [7:0] g_rnd;
    logic [7:0] b_rnd;

    always_comb begin
        r_rnd   = sat_add_u8(c_r_reg, 8'd4);
        g_rnd   = sat_add_u8(c_g_reg, 8'd2);
        b_rnd   = sat_add_u8(c_b_reg, 8'd4);
        r5_next = 5'(r_rnd >> 3);
        g6_next = 6'(g_rnd >> 2);
        b5_next = 5'(b_rnd >> 3);
    end
`else
    always_comb begin
        r5_next = 5'(c_r_reg >> 3);
        g6_next = 6'(c_g_reg >> 2);
        b5_next = 5'(c_b_reg >> 3);
    end
`endif

    logic [4:0] o_r_reg;
    logic [5:0] o_g_reg;
    logic [4:0] o_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_r_reg <= '0;
            o_g_reg <= '0;
            o_b_reg <= '0;
        end else begin
            o_r_reg <= r5_next;
            o_g_reg <= g6_next;
            o_b_reg <= b5_next;
        end
    end

    // Timing signals ride a matching delay line so they stay pixel-aligned.
    logic [2:0] sync_out;

    video_sync_dly #(
        .DEPTH (PIPE_LAT)
    ) u_sync_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  ({bus.pre_frame_vsync, bus.pre_frame_hsync, bus.pre_frame_de}),
        .sync_out (sync_out)
    );

    logic blank;

    assign bus.post_frame_vsync = sync_out[2];
    assign bus.post_frame_hsync = sync_out[1];
    assign bus.post_frame_de    = sync_out[0];

    // sync_out[0] is the de that belongs to the stage-4 pixel.
    assign blank         = BLANK_ZERO && !sync_out[0];
    assign bus.img_red   = blank ? '0 : o_r_reg;
    assign bus.img_green = blank ? '0 : o_g_reg;
    assign bus.img_blue  = blank ? '0 : o_b_reg;

endmodule

// File: tb/tb_ycbcr2rgb565.sv
// Directed-vector bench for ycbcr2rgb565: table vectors, sync burst, and reset corner cases.
module tb_ycbcr2rgb565;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic        de;
        logic [7:0]  y;
        logic [7:0]  cb;
        logic [7:0]  cr;
        logic [15:0] exp;
    } vec_t;

    localparam int NTBL  = 8;
    localparam int NBURST = 660;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    ycbcr2rgb565_if bus ();

    ycbcr2rgb565 #(
        .BLANK_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rgb(input int r, input int g, input int b);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = 5'(r);
        g6 = 6'(g);
        b5 = 5'(b);
        return {r5, g6, b5};
    endfunction

    function automatic int clamp255(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int red5(input int v8);
`ifdef YCBCR2RGB_ROUND_EN
        return clamp255(v8 + 4) / 8;
`else
        return v8 / 8;
`endif
    endfunction

    function automatic int green6(input int v8);
`ifdef YCBCR2RGB_ROUND_EN
        return clamp255(v8 + 2) / 4;
`else
        return v8 / 4;
`endif
    endfunction

    // Reference conversion using plain integer arithmetic.
    function automatic logic [15:0] model(input logic de, input int y, input int cb, input int cr);
        int r, g, b;
        if (!de) return 16'h0000;
        r = clamp255((256 * y + 359 * (cr - 128)) >>> 8);
        g = clamp255((256 * y - 88 * (cb - 128) - 183 * (cr - 128)) >>> 8);
        b = clamp255((256 * y + 454 * (cb - 128)) >>> 8);
        return rgb(red5(r), green6(g), red5(b));
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.pre_frame_vsync = v.vs;
        bus.pre_frame_hsync = v.hs;
        bus.pre_frame_de    = v.de;
        bus.img_y           = v.y;
        bus.img_cb          = v.cb;
        bus.img_cr          = v.cr;
    endtask

    function automatic logic [18:0] all_out();
        return {bus.post_frame_vsync, bus.post_frame_hsync, bus.post_frame_de,
                bus.img_red, bus.img_green, bus.img_blue};
    endfunction

    vec_t tbl [NTBL];
    vec_t stim [$];
    vec_t idle_v;

    // Feed stim back-to-back; the output seen after edge c belongs to input c-4.
    task automatic run_stream();
        int   n;
        vec_t e;
        n = stim.size();
        for (int c = 0; c < n + 4; c++) begin
            @(posedge clk);
            #1;
            if (c >= 4) begin
                e = stim[c-4];
                check("sync", c - 4,
                      32'({bus.post_frame_vsync, bus.post_frame_hsync, bus.post_frame_de}),
                      32'({e.vs, e.hs, e.de}));
                check("rgb", c - 4, 32'({bus.img_red, bus.img_green, bus.img_blue}), 32'(e.exp));
                if (c - 4 < NTBL) begin
                    $display("vec %0d: y=%0d cb=%0d cr=%0d de=%0d -> r=%0d g=%0d b=%0d",
                             c - 4, e.y, e.cb, e.cr, e.de, bus.img_red, bus.img_green, bus.img_blue);
                end
            end
            if (c < n) drive(stim[c]);
            else       drive(idle_v);
        end
    endtask

    initial begin
        vec_t v;
        int   first_k;

        pass_cnt  = 0;
        total_cnt = 0;
        idle_v    = '0;

        // Hand-computed vectors {vs, hs, de, Y, Cb, Cr, RGB565}
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'd128, 8'd128, 8'd128, rgb(16, 32, 16)};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128, rgb(31, 63, 31)};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'd128, 8'd128, rgb(0, 0, 0)};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd0,   8'd128, 8'd255, rgb(22, 0, 0)};
`ifdef YCBCR2RGB_ROUND_EN
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd255, rgb(31, 52, 4)};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'd100, 8'd200, 8'd50,  rgb(0, 33, 28)};
`else
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd255, rgb(31, 52, 3)};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'd100, 8'd200, 8'd50,  rgb(0, 32, 28)};
`endif
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd255, 8'd128, 8'd128, rgb(0, 0, 0)};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'd16,  8'd128, 8'd128, rgb(2, 4, 2)};

        // Reset holds every output at zero even with live input.
        rst_n = 1'b0;
        v = '{1'b1, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128, 16'h0};
        drive(v);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 0, 32'(all_out()), 32'd0);
        drive(idle_v);
        rst_n = 1'b1;

        for (int i = 0; i < NTBL; i++) stim.push_back(tbl[i]);

        // Line burst: hsync pulses, back-to-back vsync pulses, random pixels.
        for (int i = 0; i < NBURST; i++) begin
            v.de = (i >= 10 && i < 650);
            v.hs = ((i % 80) < 8);
            v.vs = (i < 3) || (i == 300) || (i == 302);
            v.y  = 8'($urandom_range(0, 255));
            v.cb = 8'($urandom_range(0, 255));
            v.cr = 8'($urandom_range(0, 255));
            v.exp = model(v.de, int'(v.y), int'(v.cb), int'(v.cr));
            stim.push_back(v);
        end
        run_stream();
        $display("burst of %0d pixels done", NBURST);

        // Mid-line reset: outputs clear at once, restart latency is exactly 4 clk.
        v = '{1'b0, 1'b1, 1'b1, 8'd200, 8'd128, 8'd128, 16'h0};
        drive(v);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_pixel", 0, 32'({bus.img_red, bus.img_green, bus.img_blue}), 32'(rgb(25, 50, 25)));
        rst_n = 1'b0;
        drive(idle_v);
        #1;
        check("reset_immediate", 0, 32'(all_out()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", i, 32'(all_out()), 32'd0);
        end
        v = '{1'b0, 1'b0, 1'b1, 8'd128, 8'd128, 8'd128, 16'h0};
        drive(v);
        first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (first_k == 0 && all_out() != 19'd0) first_k = k;
        end
        check("first_pixel_latency", 0, 32'(first_k), 32'd4);
        check("first_pixel_value", 0, 32'({bus.img_red, bus.img_green, bus.img_blue}), 32'(rgb(16, 32, 16)));
        $display("reset restart: first output after %0d clk", first_k);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ycbcr2rgb565.md
# ycbcr2rgb565

Pixel-stream colour-space converter: takes 8-bit YCbCr 4:4:4 pixels with their vsync/hsync/de timing and produces RGB565 pixels for the LCD/VGA output path. It is the inverse of the front-end RGB565→YCbCr stage. It sits after the YCbCr-domain processing blocks (filters, thresholding) and before the display/framebuffer writer. It is a fixed-latency 4-stage pipeline with integer coefficients, saturation and 888→565 reduction. It has no back-pressure.

## Interface
Parameters:
- BLANK_ZERO, default 1: when 1, img_red/img_green/img_blue are forced to 0 while post_frame_de is low; when 0, pipeline data passes through regardless of de.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- pre_frame_vsync  input  1  input vsync
- pre_frame_hsync  input  1  input hsync
- pre_frame_de  input  1  input data enable
- img_y  input  8  luma, unsigned
- img_cb  input  8  blue-difference chroma, offset-128
- img_cr  input  8  red-difference chroma, offset-128
- post_frame_vsync  output  1  vsync delayed 4 cycles
- post_frame_hsync  output  1  hsync delayed 4 cycles
- post_frame_de  output  1  de delayed 4 cycles
- img_red  output  5  R565
- img_green  output  6  G565
- img_blue  output  5  B565

## Operation
- Equations, scaled by 256; cb = Cb-128 and cr = Cr-128 are signed 9-bit:
  - R = (256Y + 359cr) >>> 8
  - G = (256Y − 88cb − 183cr) >>> 8
  - B = (256Y + 454cb) >>> 8
- Stage 1 registers the products: Y<<8, 359cr, 88cb, 183cr, 454cb, each 18-bit signed.
- Stage 2 registers the three sums as 18-bit signed. The range is provably −58112..+122938, so there is no overflow.
- Stage 3 applies an arithmetic shift right by 8 (floor), then clamps to 0..255. Negative values become 0; values above 255 become 255. The result is registered as R8/G8/B8.
- Stage 4 reduces to 565 (see Configuration). If BLANK_ZERO=1 and stage-4 de is low, all three outputs are 0.
- The sync signals (vsync, hsync, de) pass through a 4-deep shift register, aligned exactly with the data.
- There is no state machine. Every stage loads every cycle, and data is accepted while de is low.

## Timing
- Latency: 4 clk from a pre_* input to the matching post_* output, for both data and sync.
- Throughput: 1 pixel per clk, with no gaps required between pixels.
- Reset: all pipeline registers and sync delay bits are asynchronously cleared. All outputs read 0 from rst_n assertion until 4 clk after the first valid input following deassertion.
- Reset mid-line: the in-flight pixels are discarded. No partial-pixel or glitched sync is emitted.
- Back-to-back frames: vsync edges are preserved cycle-exact, with no merging or stretching.

## Configuration
- YCBCR2RGB_ROUND_EN defined: the 888→565 reduction rounds half-up with saturation.
  - R5 = min(R8+4, 255) >> 3
  - G6 = min(G8+2, 255) >> 2
  - B5 likewise to R5.
  - The extra add/compare lives inside stage 4, so latency is unchanged.
- YCBCR2RGB_ROUND_EN undefined: plain truncation.
  - R5 = R8[7:3], G6 = G8[7:2], B5 = B8[7:3].

## Structure
- Shared package ycbcr_pkg holds:
  - coefficient constants K_R_CR=359, K_G_CB=88, K_G_CR=183, K_B_CB=454
  - SUM_W=18 and CHROMA_OFS=128
  - PIPE_LAT=4
- The forward converter also takes its coefficients from this package.
- One sub-module: video_sync_dly, a parameterised DEPTH shift register for {vsync,hsync,de}, with async reset. It is instantiated with DEPTH=PIPE_LAT and is reusable by other pipeline stages.

## Test plan
- Y=128, Cb=128, Cr=128, de=1 → 4 clk later R8=G8=B8=128; img_red=16, img_green=32, img_blue=16 in both configurations.
- Y=255, Cb=128, Cr=128 → 31/63/31; Y=0, Cb=128, Cr=128 → 0/0/0.
- Y=0, Cb=128, Cr=255 (negative G clamp) → R8=178, G8=0, B8=0 → img_red=22, img_green=0, img_blue=0.
- Y=255, Cb=0, Cr=255 (R saturates) → R8=255, G8=208, B8=28:
  - without YCBCR2RGB_ROUND_EN: 31/52/3
  - with YCBCR2RGB_ROUND_EN: 31/52/4
- Sync alignment: a 640-pixel de burst with hsync/vsync toggling and random data → post_* equal pre_* delayed exactly 4 clk. With BLANK_ZERO=1, RGB is 0 whenever post_frame_de=0.
- Assert rst_n low mid-burst for 1 clk → all outputs 0 immediately. After release, the first nonzero pixel appears exactly 4 clk after the first de=1 input.
